reg_file_wb: RTL and testbench
==============================

Name: reg_file_wb

Overview:
8 x 8-bit register file with an integrated writeback stage. It sits directly around the 8-bit ALU in the single-cycle datapath.
- Read ports 1/2 feed the ALU's DATA1/DATA2 operand inputs.
- The write port consumes the ALU's OUTPUT and ZERO.
- A pending-write scoreboard raises STALL when an operand or destination register still awaits its result, so multi-cycle ops (e.g. MULT) can retire later.

Parameters:
DATA_WIDTH, 8, register and data bus width
NUM_REGS, 8, number of architectural registers
ADDR_WIDTH, 3, register address width (log2 NUM_REGS)
BYPASS, 1, 1 = same-cycle write-to-read forwarding enabled; 0 = reads see stored value only

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET_N  input  1  asynchronous, active-low reset
WRITEENABLE  input  1  write IN to INADDRESS at next rising edge
INADDRESS  input  ADDR_WIDTH  write destination
IN  input  DATA_WIDTH  write data (ALU OUTPUT)
ZERO_IN  input  1  ALU ZERO accompanying the write
OUT1ADDRESS  input  ADDR_WIDTH  read port 1 address
OUT2ADDRESS  input  ADDR_WIDTH  read port 2 address
RD1_EN  input  1  port 1 operand is used by the current instruction
RD2_EN  input  1  port 2 operand is used by the current instruction
ISSUE_VALID  input  1  current instruction will write ISSUE_ADDRESS later
ISSUE_ADDRESS  input  ADDR_WIDTH  destination being reserved
OUT1  output  DATA_WIDTH  read data port 1 (ALU DATA1)
OUT2  output  DATA_WIDTH  read data port 2 (ALU DATA2)
ZERO_FLAG  output  1  registered zero flag of the last write
STALL  output  1  hazard; the instruction must not advance

Behaviour:
- Reset:
  - RESET_N low asynchronously clears all registers, PENDING[NUM_REGS-1:0] and ZERO_FLAG to 0.
  - While RESET_N is low: OUT1/OUT2 read 0, STALL=0, and writes and issues are ignored.
  - Reset mid-operation discards every outstanding reservation.
- Write:
  - On a rising edge with WRITEENABLE=1: REGS[INADDRESS] <= IN and ZERO_FLAG <= ZERO_IN.
  - Register 0 is an ordinary register (not hardwired).
- Read:
  - Combinational, zero cycles.
  - If BYPASS=1 and WRITEENABLE=1 and OUTnADDRESS==INADDRESS, OUTn = IN; otherwise OUTn = REGS[OUTnADDRESS].
  - Both ports may address the same register.
- Scoreboard:
  - On a rising edge, issue_fire = ISSUE_VALID & ~STALL.
  - issue_fire sets PENDING[ISSUE_ADDRESS].
  - WRITEENABLE clears PENDING[INADDRESS].
  - If set and clear hit the same index in the same edge, set wins (the new reservation survives).
  - A write to a non-pending register is legal; no error and no state change beyond the data write.
- STALL (combinational):
  - STALL = hazard1 | hazard2 | waw.
  - hazardn = RDn_EN & PENDING[OUTnADDRESS] & ~fwdn.
  - fwdn = BYPASS & WRITEENABLE & (INADDRESS==OUTnADDRESS).
  - waw = ISSUE_VALID & PENDING[ISSUE_ADDRESS] & ~(WRITEENABLE & INADDRESS==ISSUE_ADDRESS).
  - With BYPASS=0, a same-cycle write does not cover a read hazard (fwdn=0), but it still resolves waw.
- Widths:
  - All addresses are full ADDR_WIDTH compares.
  - Out-of-range addresses are impossible with NUM_REGS = 2^ADDR_WIDTH; this block requires that equality.
- Timing:
  - Purely cycle-based; no # delays inside this block.
  - ALU delays remain in the ALU.

Decomposition:
- Shared package cpu_pkg holds DATA_WIDTH, ADDR_WIDTH and NUM_REGS constants, plus a reg_addr_t typedef reused by the ALU, control unit and this block.
- One sub-module, reg_scoreboard, owns PENDING, the set/clear priority, and STALL generation.
- The top level owns storage, the read muxes with bypass, and ZERO_FLAG.

Test Plan:
- Reset: preload r3=0x5A, assert RESET_N=0 between edges -> OUT1 (addr 3)=0x00 immediately, ZERO_FLAG=0, STALL=0 with no clock edge.
- Write/read: WRITEENABLE=1, INADDRESS=2, IN=0x0F, ZERO_IN=0, edge; then OUT1ADDRESS=2, OUT2ADDRESS=2 -> OUT1=OUT2=0x0F, ZERO_FLAG=0.
- Bypass: BYPASS=1, r4=0x11, same cycle WRITEENABLE=1 INADDRESS=4 IN=0x99 -> OUT1=0x99 before the edge. With BYPASS=0 -> 0x11 before the edge, 0x99 after.
- RAW stall: ISSUE_VALID=1 ISSUE_ADDRESS=5, edge; next cycle RD1_EN=1 OUT1ADDRESS=5 -> STALL=1. RD1_EN=0 -> STALL=0. WRITEENABLE=1 INADDRESS=5 IN=0x00 ZERO_IN=1 (BYPASS=1) -> STALL=0 that cycle; after the edge PENDING[5]=0, ZERO_FLAG=1.
- Set/clear collision: PENDING[6]=1, same edge WRITEENABLE INADDRESS=6 and ISSUE_VALID ISSUE_ADDRESS=6 -> r6 written, PENDING[6] remains 1.
- WAW and mid-op reset: PENDING[1]=1, ISSUE_VALID ISSUE_ADDRESS=1 -> STALL=1 and no new set on the edge. Pulse RESET_N low -> PENDING all 0, STALL=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared datapath constants and the register-address type used by the ALU,
// control unit and register file.
package cpu_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 3;
  localparam int NUM_REGS   = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_wb_scoreboard.sv
// Pending-write scoreboard: tracks reserved destinations and raises STALL on
// read-after-write and write-after-write hazards.
module reg_scoreboard #(
  parameter int NUM_REGS   = cpu_pkg::NUM_REGS,
  parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
  parameter int BYPASS     = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic                  i_rd1_en,
  input  logic [ADDR_WIDTH-1:0] i_rd1_addr,
  input  logic                  i_rd2_en,
  input  logic [ADDR_WIDTH-1:0] i_rd2_addr,
  input  logic                  i_issue_valid,
  input  logic [ADDR_WIDTH-1:0] i_issue_addr,
  output logic                  o_stall
);

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;
  logic                w_fwd1;
  logic                w_fwd2;
  logic                w_hz1;
  logic                w_hz2;
  logic                w_waw;

  assign w_fwd1  = (BYPASS != 0) & i_we & (i_waddr == i_rd1_addr);
  assign w_fwd2  = (BYPASS != 0) & i_we & (i_waddr == i_rd2_addr);
  assign w_hz1   = i_rd1_en & r_pending[i_rd1_addr] & ~w_fwd1;
  assign w_hz2   = i_rd2_en & r_pending[i_rd2_addr] & ~w_fwd2;
  // A write landing on the reserved destination this cycle retires the old
  // reservation, so the new issue may proceed even without bypass.
  assign w_waw   = i_issue_valid & r_pending[i_issue_addr] & ~(i_we & (i_waddr == i_issue_addr));
  assign o_stall = w_hz1 | w_hz2 | w_waw;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_issue_valid && !o_stall) w_set[i_issue_addr] = 1'b1;
    if (i_we)                      w_clr[i_waddr]      = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_pending <= '0;
    else          r_pending <= (r_pending & ~w_clr) | w_set;
  end

endmodule

// File: rtl/reg_file_wb.sv
// 8x8 register file with writeback of ALU OUTPUT/ZERO, optional same-cycle
// write-to-read bypass and a pending-write hazard scoreboard.
module reg_file_wb #(
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int NUM_REGS   = cpu_pkg::NUM_REGS,
  parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
  parameter int BYPASS     = 1
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  WRITEENABLE,
  input  logic [ADDR_WIDTH-1:0] INADDRESS,
  input  logic [DATA_WIDTH-1:0] IN,
  input  logic                  ZERO_IN,
  input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
  input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
  input  logic                  RD1_EN,
  input  logic                  RD2_EN,
  input  logic                  ISSUE_VALID,
  input  logic [ADDR_WIDTH-1:0] ISSUE_ADDRESS,
  output logic [DATA_WIDTH-1:0] OUT1,
  output logic [DATA_WIDTH-1:0] OUT2,
  output logic                  ZERO_FLAG,
  output logic                  STALL
);

  import cpu_pkg::*;

  if (NUM_REGS != (1 << ADDR_WIDTH)) begin : g_size_check
    $error("reg_file_wb: NUM_REGS must equal 2**ADDR_WIDTH");
  end

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic                  r_zero;
  logic                  w_fwd1;
  logic                  w_fwd2;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_zero <= 1'b0;
    end else if (WRITEENABLE) begin
      r_regs[INADDRESS] <= IN;
      r_zero            <= ZERO_IN;
    end
  end

  // Forwarding is gated by reset so reads stay at zero while reset is held.
  assign w_fwd1 = (BYPASS != 0) & RESET_N & WRITEENABLE & (INADDRESS == OUT1ADDRESS);
  assign w_fwd2 = (BYPASS != 0) & RESET_N & WRITEENABLE & (INADDRESS == OUT2ADDRESS);

  always_comb begin
    OUT1 = '0;
    OUT2 = '0;
    if (RESET_N) begin
      OUT1 = w_fwd1 ? IN : r_regs[OUT1ADDRESS];
      OUT2 = w_fwd2 ? IN : r_regs[OUT2ADDRESS];
    end
  end

  assign ZERO_FLAG = r_zero;

  reg_scoreboard #(
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYPASS     (BYPASS)
  ) u_scoreboard (
    .i_clk         (CLK),
    .i_rst_n       (RESET_N),
    .i_we          (WRITEENABLE),
    .i_waddr       (INADDRESS),
    .i_rd1_en      (RD1_EN),
    .i_rd1_addr    (OUT1ADDRESS),
    .i_rd2_en      (RD2_EN),
    .i_rd2_addr    (OUT2ADDRESS),
    .i_issue_valid (ISSUE_VALID),
    .i_issue_addr  (ISSUE_ADDRESS),
    .o_stall       (STALL)
  );

endmodule

// File: tb/tb_reg_file_wb.sv
// Scoreboard bench for reg_file_wb: one instance with bypass, one without,
// sharing all stimulus.
module tb_reg_file_wb;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       WRITEENABLE;
  logic [2:0] INADDRESS;
  logic [7:0] IN;
  logic       ZERO_IN;
  logic [2:0] OUT1ADDRESS;
  logic [2:0] OUT2ADDRESS;
  logic       RD1_EN;
  logic       RD2_EN;
  logic       ISSUE_VALID;
  logic [2:0] ISSUE_ADDRESS;

  logic [7:0] out1_a, out2_a, out1_b, out2_b;
  logic       zf_a, st_a, zf_b, st_b;

  always #20 CLK = ~CLK;

  reg_file_wb #(.BYPASS(1)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .WRITEENABLE(WRITEENABLE), .INADDRESS(INADDRESS),
    .IN(IN), .ZERO_IN(ZERO_IN), .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .RD1_EN(RD1_EN), .RD2_EN(RD2_EN), .ISSUE_VALID(ISSUE_VALID), .ISSUE_ADDRESS(ISSUE_ADDRESS),
    .OUT1(out1_a), .OUT2(out2_a), .ZERO_FLAG(zf_a), .STALL(st_a)
  );

  reg_file_wb #(.BYPASS(0)) dut_nb (
    .CLK(CLK), .RESET_N(RESET_N), .WRITEENABLE(WRITEENABLE), .INADDRESS(INADDRESS),
    .IN(IN), .ZERO_IN(ZERO_IN), .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .RD1_EN(RD1_EN), .RD2_EN(RD2_EN), .ISSUE_VALID(ISSUE_VALID), .ISSUE_ADDRESS(ISSUE_ADDRESS),
    .OUT1(out1_b), .OUT2(out2_b), .ZERO_FLAG(zf_b), .STALL(st_b)
  );

  typedef enum int {S_OUT1, S_OUT2, S_ZERO, S_STALL, S_NB_OUT1, S_NB_STALL} sig_e;
  typedef struct {
    string      name;
    sig_e       sig;
    logic [7:0] val;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   checks = 0;
  int   errors = 0;

  // Monitor: on each sample request, drain expectations and compare.
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(chk_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.sig)
          S_OUT1:     act = out1_a;
          S_OUT2:     act = out2_a;
          S_ZERO:     act = {7'b0, zf_a};
          S_STALL:    act = {7'b0, st_a};
          S_NB_OUT1:  act = out1_b;
          default:    act = {7'b0, st_b};
        endcase
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, act, e.val);
        end
      end
    end
  end

  task automatic expect_v(input string name, input sig_e sig, input logic [7:0] val);
    exp_t e;
    e.name = name; e.sig = sig; e.val = val;
    q.push_back(e);
  endtask

  task automatic check_now();
    #1;
    ->chk_ev;
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL monitor_drain: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    WRITEENABLE = 0; INADDRESS = 0; IN = 0; ZERO_IN = 0;
    RD1_EN = 0; RD2_EN = 0; ISSUE_VALID = 0; ISSUE_ADDRESS = 0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d, input logic z);
    WRITEENABLE = 1; INADDRESS = a; IN = d; ZERO_IN = z;
  endtask

  initial begin
    idle();
    OUT1ADDRESS = 0; OUT2ADDRESS = 0;
    RESET_N = 0;
    expect_v("reset_out1", S_OUT1, 8'h00);
    expect_v("reset_zero", S_ZERO, 8'h00);
    expect_v("reset_stall", S_STALL, 8'h00);
    check_now();
    @(negedge CLK);
    RESET_N = 1;

    // Preload r3, then reset between edges
    tick(); wr(3'd3, 8'h5A, 1'b1);
    tick(); idle(); OUT1ADDRESS = 3;
    expect_v("preload_r3", S_OUT1, 8'h5A);
    expect_v("preload_zero", S_ZERO, 8'h01);
    check_now();
    RESET_N = 0;
    expect_v("async_reset_out1", S_OUT1, 8'h00);
    expect_v("async_reset_zero", S_ZERO, 8'h00);
    expect_v("async_reset_stall", S_STALL, 8'h00);
    check_now();
    RESET_N = 1;

    // Write/read both ports same register
    tick(); wr(3'd2, 8'h0F, 1'b0);
    tick(); idle(); OUT1ADDRESS = 2; OUT2ADDRESS = 2;
    expect_v("rd_p1_r2", S_OUT1, 8'h0F);
    expect_v("rd_p2_r2", S_OUT2, 8'h0F);
    expect_v("rd_zero", S_ZERO, 8'h00);
    check_now();

    // Bypass vs no bypass
    wr(3'd4, 8'h11, 1'b0);
    tick(); wr(3'd4, 8'h99, 1'b0); OUT1ADDRESS = 4;
    expect_v("bypass_on", S_OUT1, 8'h99);
    expect_v("bypass_off", S_NB_OUT1, 8'h11);
    check_now();
    tick(); idle();
    expect_v("after_edge_on", S_OUT1, 8'h99);
    expect_v("after_edge_off", S_NB_OUT1, 8'h99);
    check_now();

    // RAW stall on r5
    ISSUE_VALID = 1; ISSUE_ADDRESS = 5;
    tick(); idle(); RD1_EN = 1; OUT1ADDRESS = 5;
    expect_v("raw_stall", S_STALL, 8'h01);
    expect_v("raw_stall_nb", S_NB_STALL, 8'h01);
    check_now();
    RD1_EN = 0;
    expect_v("raw_unused", S_STALL, 8'h00);
    check_now();
    RD1_EN = 1; wr(3'd5, 8'h00, 1'b1);
    expect_v("raw_fwd_covers", S_STALL, 8'h00);
    expect_v("raw_nofwd_stalls", S_NB_STALL, 8'h01);
    check_now();
    tick(); idle(); RD1_EN = 1; OUT1ADDRESS = 5;
    expect_v("raw_cleared", S_STALL, 8'h00);
    expect_v("raw_cleared_nb", S_NB_STALL, 8'h00);
    expect_v("raw_zero_set", S_ZERO, 8'h01);
    expect_v("raw_r5", S_OUT1, 8'h00);
    check_now();
    RD1_EN = 0;

    // Set/clear collision on r6
    ISSUE_VALID = 1; ISSUE_ADDRESS = 6;
    tick(); wr(3'd6, 8'h66, 1'b0);
    expect_v("collide_no_waw", S_STALL, 8'h00);
    check_now();
    tick(); idle(); RD1_EN = 1; OUT1ADDRESS = 6;
    expect_v("collide_pending", S_STALL, 8'h01);
    expect_v("collide_data", S_OUT1, 8'h66);
    expect_v("collide_zero", S_ZERO, 8'h00);
    check_now();
    RD1_EN = 0; wr(3'd6, 8'h66, 1'b0);
    tick(); idle();

    // WAW on r1; a stalled issue must not reserve
    ISSUE_VALID = 1; ISSUE_ADDRESS = 1;
    tick(); idle(); ISSUE_VALID = 1; ISSUE_ADDRESS = 1;
    expect_v("waw_stall", S_STALL, 8'h01);
    check_now();
    ISSUE_VALID = 0; RD2_EN = 1; OUT2ADDRESS = 1; OUT1ADDRESS = 0;
    expect_v("port2_hazard", S_STALL, 8'h01);
    check_now();
    RD2_EN = 0; RD1_EN = 1; OUT1ADDRESS = 1; ISSUE_VALID = 1; ISSUE_ADDRESS = 7;
    expect_v("raw_blocks_issue", S_STALL, 8'h01);
    check_now();
    tick(); idle(); RD1_EN = 1; OUT1ADDRESS = 7;
    expect_v("stalled_issue_dropped", S_STALL, 8'h00);
    check_now();
    OUT1ADDRESS = 1;
    expect_v("r1_still_pending", S_STALL, 8'h01);
    check_now();

    // Mid-op reset discards reservations
    ISSUE_VALID = 1; ISSUE_ADDRESS = 1;
    RESET_N = 0;
    expect_v("midreset_stall", S_STALL, 8'h00);
    check_now();
    RESET_N = 1; ISSUE_VALID = 0;
    expect_v("postreset_r1_free", S_STALL, 8'h00);
    expect_v("postreset_r1_free_nb", S_NB_STALL, 8'h00);
    check_now();
    tick(); idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
